linked_list_drain: RTL

Read-side scheduler for the shared-memory linked-list FIFO block. It watches the per-FIFO empty flags and issues one-hot pops using round-robin arbitration with an optional per-FIFO burst allowance. It captures the popped word and presents it, tagged with its FIFO index, on a valid/ready output stream through a 2-entry buffer. It sits between the linked-list FIFO's pop/empty/data_out side and the downstream consumer.

---
 rtl/linked_list_drain.sv | 137 +++++++++++++
 1 files changed

// File: rtl/linked_list_drain.sv
// linked_list_drain
//   Read-side scheduler for the shared-memory linked-list FIFO block.
//   It arbitrates between the per-FIFO empty flags with round-robin plus
//   an optional per-FIFO burst allowance, and issues at most one one-hot
//   pop per cycle. The popped head word is captured, together with its
//   FIFO index, into a 2-entry buffer that feeds a valid/ready stream.
//
// Ports
//   clk        system clock, all state changes on posedge
//   rst        asynchronous active-high reset
//   en         when low no new pops are issued; buffered words still drain
//   fifo_empty per-FIFO empty flags (registered in the FIFO block)
//   fifo_data  head word of the FIFO currently selected by fifo_pop
//   fifo_pop   zero or one-hot pop request
//   out_valid  output word available
//   out_ready  consumer accepts the word this cycle
//   out_data   oldest buffered word
//   out_id     source FIFO index of out_data
module linked_list_drain #(
  parameter int WIDTH     = 8,
  parameter int NUM_FIFOS = 2,
  parameter int BURST     = 1,
  parameter int ID_WIDTH  = $clog2(NUM_FIFOS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [NUM_FIFOS-1:0] fifo_empty,
  input  logic [WIDTH-1:0]     fifo_data,
  output logic [NUM_FIFOS-1:0] fifo_pop,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [ID_WIDTH-1:0]  out_id
);

  localparam int CNT_W = (BURST < 1) ? 1 : $clog2(BURST + 1);

  // Arbitration state
  logic [ID_WIDTH-1:0] last_grant;
  logic [CNT_W-1:0]    burst_cnt;

  // Arbitration result
  logic [ID_WIDTH-1:0] grant;
  logic                grant_valid;

  // Output buffer
  logic [WIDTH-1:0]    buf_data [2];
  logic [ID_WIDTH-1:0] buf_id   [2];
  logic                wr_ptr;
  logic                rd_ptr;
  logic [1:0]          count;

  logic                pop_ok;
  logic                do_pop;
  logic                accept;

  // pop_ok only looks at the buffer occupancy, never at out_ready, so the
  // pop request has no combinational path from the consumer.
  assign pop_ok    = en && !rst && (count < 2'd2);
  assign do_pop    = pop_ok && grant_valid;
  assign out_valid = (count != 2'd0);
  assign accept    = out_valid && out_ready;
  assign out_data  = buf_data[rd_ptr];
  assign out_id    = buf_id[rd_ptr];

  // burst_cnt==0 means nothing has been granted since reset, so the reset
  // value of last_grant is only a rotation origin (first grant starts at
  // FIFO 0) and never earns a repeat grant.
  always_comb begin
    int unsigned idx;
    grant       = '0;
    grant_valid = 1'b0;
    idx         = 0;
    if ((burst_cnt != '0) && (burst_cnt < CNT_W'(BURST)) &&
        !fifo_empty[last_grant]) begin
      grant       = last_grant;
      grant_valid = 1'b1;
    end else begin
      // Search strictly after last_grant, wrapping round to last_grant itself.
      for (int unsigned k = 1; k <= NUM_FIFOS; k++) begin
        idx = 32'(last_grant) + k;
        if (idx >= NUM_FIFOS) idx = idx - NUM_FIFOS;
        if (!grant_valid && !fifo_empty[ID_WIDTH'(idx)]) begin
          grant       = ID_WIDTH'(idx);
          grant_valid = 1'b1;
        end
      end
    end
  end

  always_comb begin
    fifo_pop = '0;
    if (do_pop) fifo_pop[grant] = 1'b1;
  end

  // Arbitration state only advances on an actual pop, so it holds while
  // en is low, while the buffer is full, and while every FIFO is empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= ID_WIDTH'(NUM_FIFOS - 1);
      burst_cnt  <= '0;
    end else if (do_pop) begin
      last_grant <= grant;
      if (grant == last_grant) begin
        if (burst_cnt < CNT_W'(BURST)) burst_cnt <= burst_cnt + 1'b1;
      end else begin
        burst_cnt <= CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 2; i++) begin
        buf_data[i] <= '0;
        buf_id[i]   <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_pop) begin
        buf_data[wr_ptr] <= fifo_data;
        buf_id[wr_ptr]   <= grant;
        wr_ptr           <= ~wr_ptr;
      end
      if (accept) rd_ptr <= ~rd_ptr;
      case ({do_pop, accept})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule
